iob_eth_mdio: RTL and testbench



---
 rtl/iob_eth_mdio.sv | 211 +++++++++++++++++++++
 tb/tb_iob_eth_mdio.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_mdio.sv
// -----------------------------------------------------------------------------
// iob_eth_mdio
// MII management (MDIO/MDC) master. Serialises one IEEE 802.3 clause-22 read
// or write frame per request and returns the read data and PHY-response status.
//
// Build option:
//   IOB_ETH_MDIO_PREAMBLE_EN  defined   -> 32-bit all-ones preamble, 64-bit frame
//                             undefined -> preamble suppressed, 32-bit frame
//
// Ports:
//   clk_i, arst_n_i        system clock, asynchronous active-low reset
//   cke_i                  clock enable; low freezes all state
//   clk_div_i              MDC half-period H in clk_i cycles (0,1 act as 2)
//   start_i                frame request, sampled only in IDLE
//   op_rd_i                1 = read, 0 = write
//   phy_addr_i, reg_addr_i PHYAD / REGAD
//   wdata_i                write data
//   busy_o                 frame in progress
//   done_o                 one-cycle completion pulse
//   rdata_o, nack_o        last read data / no-PHY flag from last read
//   mdc_o, mdio_o          management clock / MDIO output data
//   mdio_oe_o              MDIO output enable (1 = drive pad)
//   mdio_i                 MDIO input from pad
//   dbg_state_o            current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Request handshake: start_i is accepted only on a cycle where cke_i=1 and the
// FSM is in IDLE (busy_o=0, done_o=0); all request fields are captured on that
// cycle. busy_o rises on the following cycle and stays high for the whole
// frame; done_o pulses for one cycle after busy_o falls, together with the
// updated rdata_o/nack_o. Requests made while busy or during done_o are
// dropped, never queued.
// -----------------------------------------------------------------------------
module iob_eth_mdio #(
  parameter int CLK_DIV_W = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  input  logic [CLK_DIV_W-1:0] clk_div_i,
  input  logic                 start_i,
  input  logic                 op_rd_i,
  input  logic [4:0]           phy_addr_i,
  input  logic [4:0]           reg_addr_i,
  input  logic [15:0]          wdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          rdata_o,
  output logic                 nack_o,
  output logic                 mdc_o,
  output logic                 mdio_o,
  output logic                 mdio_oe_o,
  input  logic                 mdio_i,
  output logic [1:0]           dbg_state_o
);

`ifdef IOB_ETH_MDIO_PREAMBLE_EN
  localparam int FRAME_N = 64;
`else
  localparam int FRAME_N = 32;
`endif

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_N - 1);
  // Bit counter values (counting down to 0 on the last DATA bit):
  // 18 = REGAD[0], 17 = first TA bit, 16 = second TA bit, 15..0 = DATA.
  localparam logic [CNT_W-1:0] CNT_REG0 = CNT_W'(18);
  localparam logic [CNT_W-1:0] CNT_TA2  = CNT_W'(16);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [FRAME_N-1:0]     frame_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CLK_DIV_W-1:0]   half_q;
  logic [CLK_DIV_W-1:0]   hcnt_q;
  logic                   op_rd_q;
  logic [15:0]            rsh_q;
  logic                   ta_q;
  logic                   busy_q;
  logic                   done_q;
  logic [15:0]            rdata_q;
  logic                   nack_q;
  logic                   mdc_q;
  logic                   mdio_q;
  logic                   oe_q;

  // Frame image and effective half period for a request presented this cycle.
  // On reads the TA/DATA slots hold ones; the pad is released then anyway.
  logic [31:0]            core_d;
  logic [FRAME_N-1:0]     frame_d;
  logic [CLK_DIV_W-1:0]   half_d;

  always_comb begin
    core_d = {2'b01,
              (op_rd_i ? 2'b10 : 2'b01),
              phy_addr_i,
              reg_addr_i,
              (op_rd_i ? 2'b11 : 2'b10),
              (op_rd_i ? 16'hFFFF : wdata_i)};
`ifdef IOB_ETH_MDIO_PREAMBLE_EN
    frame_d = {32'hFFFF_FFFF, core_d};
`else
    frame_d = core_d;
`endif
    half_d = (clk_div_i < CLK_DIV_W'(2)) ? CLK_DIV_W'(2) : clk_div_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      half_q  <= '0;
      hcnt_q  <= '0;
      op_rd_q <= 1'b0;
      rsh_q   <= '0;
      ta_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      mdc_q   <= 1'b0;
      mdio_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else if (cke_i) begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            frame_q <= frame_d;
            cnt_q   <= LAST_BIT;
            half_q  <= half_d;
            hcnt_q  <= half_d - CLK_DIV_W'(1);
            op_rd_q <= op_rd_i;
            busy_q  <= 1'b1;
            mdc_q   <= 1'b0;
            mdio_q  <= frame_d[FRAME_N-1];
            oe_q    <= 1'b1;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          if (hcnt_q != '0) begin
            hcnt_q <= hcnt_q - CLK_DIV_W'(1);
          end else begin
            hcnt_q <= half_q - CLK_DIV_W'(1);
            if (!mdc_q) begin
              // MDC rising edge: the PHY's bit has had a full low phase to settle.
              mdc_q <= 1'b1;
              if (op_rd_q) begin
                if (cnt_q == CNT_TA2) ta_q <= mdio_i;
                if (cnt_q < CNT_TA2)  rsh_q <= {rsh_q[14:0], mdio_i};
              end
            end else begin
              // MDC falling edge: advance to the next bit or finish.
              mdc_q <= 1'b0;
              if (cnt_q == '0) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                mdio_q  <= 1'b1;
                oe_q    <= 1'b0;
                if (op_rd_q) begin
                  rdata_q <= rsh_q;
                  nack_q  <= ta_q;
                end else begin
                  nack_q  <= 1'b0;
                end
                state_q <= DONE;
              end else begin
                cnt_q   <= cnt_q - CNT_W'(1);
                frame_q <= {frame_q[FRAME_N-2:0], 1'b0};
                mdio_q  <= frame_q[FRAME_N-2];
                // Reads release the pad from the first TA bit onward.
                oe_q    <= !(op_rd_q && (cnt_q <= CNT_REG0));
              end
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          mdc_q   <= 1'b0;
          mdio_q  <= 1'b1;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign nack_o      = nack_q;
  assign mdc_o       = mdc_q;
  assign mdio_o      = mdio_q;
  assign mdio_oe_o   = oe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iob_eth_mdio.sv
// -----------------------------------------------------------------------------
// tb_iob_eth_mdio
// Self-checking bench for iob_eth_mdio. Expected MDIO bit stream per frame is
// queued when a request is driven and popped at every observed MDC rise; frame
// results (busy length, done pulse, rdata/nack) come from a vector table.
// Works in both preamble and no-preamble builds.
// -----------------------------------------------------------------------------
module tb_iob_eth_mdio;

`ifdef IOB_ETH_MDIO_PREAMBLE_EN
  localparam int N = 64;
`else
  localparam int N = 32;
`endif

  typedef struct {
    logic        op_rd;
    logic [7:0]  clk_div;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic        present;
    logic [15:0] phy_data;
    logic [15:0] exp_rdata;
    logic        exp_nack;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        arst_n_i;
  logic        cke_i;
  logic [7:0]  clk_div_i;
  logic        start_i;
  logic        op_rd_i;
  logic [4:0]  phy_addr_i;
  logic [4:0]  reg_addr_i;
  logic [15:0] wdata_i;
  logic        busy_o, done_o, nack_o, mdc_o, mdio_o, mdio_oe_o;
  logic [15:0] rdata_o;
  logic        mdio_i = 1'b1;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  iob_eth_mdio #(.CLK_DIV_W(8)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i), .clk_div_i(clk_div_i),
    .start_i(start_i), .op_rd_i(op_rd_i), .phy_addr_i(phy_addr_i),
    .reg_addr_i(reg_addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
    .done_o(done_o), .rdata_o(rdata_o), .nack_o(nack_o), .mdc_o(mdc_o),
    .mdio_o(mdio_o), .mdio_oe_o(mdio_oe_o), .mdio_i(mdio_i),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [1:0]  exp_q[$];   // {oe, mdio} per frame bit
  int          checks = 0;
  int          failures = 0;
  int          rise_cnt, busy_cnt, done_cnt, active_cnt = 0, last_rise;
  bit          have_rise, prev_mdc = 1'b0, prev_busy = 1'b0;
  logic [15:0] done_rdata;
  logic        done_nack;
  logic        cur_present = 1'b0;
  logic [15:0] cur_data = '0;
  int          cur_heff = 2;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PHY model: releases through TA bit 1, drives 0 on TA bit 2, then data.
  function automatic logic phy_bit(input int j);
    int k;
    k = j - (N - 18);
    if (!cur_present || k < 1) return 1'b1;
    if (k == 1) return 1'b0;
    if (k < 18) return cur_data[15-(k-2)];
    return 1'b1;
  endfunction

  function automatic logic [63:0] exp_frame(input vec_t v);
    logic [63:0] f;
    f = {32'hFFFF_FFFF, 2'b01, (v.op_rd ? 2'b10 : 2'b01), v.phy, v.regad,
         (v.op_rd ? 2'b11 : 2'b10), (v.op_rd ? 16'hFFFF : v.wdata)};
    return f;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0] e;
    if (cke_i) active_cnt++;
    if (busy_o) busy_cnt++;
    if (done_o) begin
      done_cnt++;
      done_rdata = rdata_o;
      done_nack  = nack_o;
      chk(prev_busy && !busy_o, "done_follows_busy", {prev_busy, busy_o}, 2'b10);
    end
    if (mdc_o && !prev_mdc) begin
      if (have_rise)
        chk((active_cnt - last_rise) == 2 * cur_heff, "mdc_period", active_cnt - last_rise, 2 * cur_heff);
      have_rise = 1'b1;
      last_rise = active_cnt;
      if (exp_q.size() == 0) begin
        chk(1'b0, "extra_bit", rise_cnt, N);
      end else begin
        e = exp_q.pop_front();
        chk(mdio_oe_o == e[1], "bit_oe", mdio_oe_o, e[1]);
        if (e[1]) chk(mdio_o == e[0], "bit_mdio", mdio_o, e[0]);
      end
      rise_cnt++;
    end
    prev_mdc  = mdc_o;
    prev_busy = busy_o;
    mdio_i    = phy_bit(rise_cnt);
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input vec_t v);
    logic [63:0] f;
    f = exp_frame(v);
    cur_present = v.present;
    cur_data    = v.phy_data;
    cur_heff    = (v.clk_div < 2) ? 2 : int'(v.clk_div);
    for (int j = 0; j < N; j++)
      exp_q.push_back({!(v.op_rd && j >= N - 18), f[N-1-j]});
    @(posedge clk); #1;
    rise_cnt = 0; busy_cnt = 0; done_cnt = 0; have_rise = 1'b0;
    clk_div_i = v.clk_div; op_rd_i = v.op_rd; phy_addr_i = v.phy;
    reg_addr_i = v.regad; wdata_i = v.wdata; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk(busy_o && !mdc_o && mdio_oe_o && (mdio_o == f[N-1]), "first_cycle",
        {busy_o, mdc_o, mdio_oe_o, mdio_o}, {3'b101, f[N-1]});
  endtask

  task automatic run_frame(input vec_t v, input int stall_at, input int stall_len, input int restart_at);
    bit stalled, restarted;
    int exp_busy;
    stalled = 1'b0; restarted = 1'b0;
    launch(v);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      if (stall_len > 0 && !stalled && rise_cnt == stall_at) begin
        cke_i = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1 cke_i = 1'b1;
        stalled = 1'b1;
      end
      if (restart_at >= 0 && !restarted && rise_cnt == restart_at) begin
        start_i = 1'b1; op_rd_i = ~v.op_rd; wdata_i = ~v.wdata; phy_addr_i = ~v.phy;
        @(posedge clk); #1;
        start_i = 1'b0;
        restarted = 1'b1;
      end
    end
    repeat (3 * cur_heff + 4) @(posedge clk);
    #1;
    exp_busy = N * 2 * cur_heff + (stalled ? stall_len : 0);
    chk(done_cnt == 1, "done_count", done_cnt, 1);
    chk(busy_cnt == exp_busy, "busy_cycles", busy_cnt, exp_busy);
    chk(done_rdata == v.exp_rdata, "rdata", done_rdata, v.exp_rdata);
    chk(done_nack == v.exp_nack, "nack", done_nack, v.exp_nack);
    chk(exp_q.size() == 0, "bits_left", exp_q.size(), 0);
    chk(!busy_o && !mdio_oe_o && mdio_o, "idle_pins", {busy_o, mdio_oe_o, mdio_o}, 3'b001);
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  vec_t vecs[6];
  vec_t hv;
  logic [15:0] rnd_w;

  initial begin
    rnd_w = 16'($urandom_range(0, 65535));
    //             rd  div   phy     reg     wdata     pres phy_data  exp_rdata exp_nack
    vecs[0] = '{1'b0, 8'd2, 5'h01, 5'h00, 16'h1200, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 8'd4, 5'h01, 5'h02, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 8'd2, 5'h07, 5'h01, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b0, 8'd0, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b1, 8'd1, 5'h0A, 5'h05, 16'h0000, 1'b1, 16'h1234, 16'h1234, 1'b0};
    vecs[5] = '{1'b0, 8'd3, 5'h12, 5'h0C, rnd_w,    1'b0, 16'h0000, 16'h1234, 1'b0};

    arst_n_i = 1'b0; cke_i = 1'b1; clk_div_i = '0; start_i = 1'b0; op_rd_i = 1'b0;
    phy_addr_i = '0; reg_addr_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 arst_n_i = 1'b1;
    @(negedge clk);
    chk({busy_o, done_o, nack_o, mdc_o, mdio_o, mdio_oe_o} == 6'b000010, "reset_pins",
        {busy_o, done_o, nack_o, mdc_o, mdio_o, mdio_oe_o}, 6'b000010);
    chk(rdata_o == 16'h0, "reset_rdata", rdata_o, 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], -1, 0, -1);

    // Second request while busy is dropped; fields changed mid-frame must not leak.
    hv = '{1'b0, 8'd0, 5'h03, 5'h04, 16'h5A5A, 1'b0, 16'h0000, 16'h1234, 1'b0};
    run_frame(hv, -1, 0, 5);

    // Clock-enable stall of 10 cycles mid-frame stretches busy by 10 only.
    hv = '{1'b0, 8'd2, 5'h01, 5'h00, 16'h1200, 1'b0, 16'h0000, 16'h1234, 1'b0};
    run_frame(hv, 8, 10, -1);

    // Asynchronous reset at bit 20 of a read.
    hv = '{1'b1, 8'd2, 5'h05, 5'h06, 16'h0000, 1'b1, 16'hCAFE, 16'hCAFE, 1'b0};
    launch(hv);
    for (int c = 0; c < 2000 && rise_cnt < 20; c++) @(posedge clk);
    #1 arst_n_i = 1'b0;
    #1;
    chk({busy_o, done_o, nack_o, mdc_o, mdio_o, mdio_oe_o} == 6'b000010, "midreset_pins",
        {busy_o, done_o, nack_o, mdc_o, mdio_o, mdio_oe_o}, 6'b000010);
    chk(rdata_o == 16'h0, "midreset_rdata", rdata_o, 0);
    chk(rise_cnt == 20, "midreset_reached", rise_cnt, 20);
    repeat (3) @(posedge clk);
    #1 arst_n_i = 1'b1;
    exp_q.delete();
    repeat (20) @(posedge clk);
    #1;
    chk(done_cnt == 0 && !busy_o, "midreset_no_done", {done_cnt[7:0], busy_o}, 9'h0);

    // A fresh frame after reset completes normally.
    run_frame(hv, -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
